// File: rtl/universal_shift_register_if.sv
// Control/data bundle for universal_shift_register.
// slave: en, mode, load_data, ser_in, start, shamt in; Q, ser_out_l/r, sticky, busy, done out.
interface universal_shift_register_if #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH) + 1
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] load_data;
  logic             ser_in;
  logic             start;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] Q;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             sticky;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, load_data, ser_in, start, shamt,
    input  Q, ser_out_l, ser_out_r, sticky, busy, done
  );

  modport slave (
    input  en, mode, load_data, ser_in, start, shamt,
    output Q, ser_out_l, ser_out_r, sticky, busy, done
  );
endinterface

// File: rtl/universal_shift_register.sv
// Width-parametric shift/rotate register with load and sequenced shift.
// Ports: clk, rst_n (async low); bus (slave) carries controls and results.
module universal_shift_register #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH) + 1
) (
  input logic clk,
  input logic rst_n,
  universal_shift_register_if.slave bus
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SLL  = 3'b010;
  localparam logic [2:0] M_SRL  = 3'b011;
  localparam logic [2:0] M_SRA  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ROR  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state, w_nstate;
  logic [WIDTH-1:0] r_q, w_nq;
  logic             r_sticky, w_nsticky;
  logic [SW-1:0]    r_cnt, w_ncnt;
  logic [2:0]       r_mode, w_nmode;
  logic             r_ser, w_nser;

  logic             w_is_shift;
  logic [SW-1:0]    w_clamp;

  function automatic logic [WIDTH-1:0] f_step(
    input logic [WIDTH-1:0] q,
    input logic [2:0]       op,
    input logic             sin
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (op)
      M_SLL:   r = {q[WIDTH-2:0], sin};
      M_SRL:   r = {sin, q[WIDTH-1:1]};
      M_SRA:   r = {q[WIDTH-1], q[WIDTH-1:1]};
      M_ROL:   r = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ROR:   r = {q[0], q[WIDTH-1:1]};
      default: r = q;
    endcase
    return r;
  endfunction

  // Right shifts fold the outgoing LSB into sticky for rounding.
  function automatic logic f_sticky(
    input logic       s,
    input logic [2:0] op,
    input logic       lsb
  );
    return s | (((op == M_SRL) || (op == M_SRA)) & lsb);
  endfunction

  assign w_is_shift = (bus.mode >= M_SLL) && (bus.mode <= M_ROR);
  assign w_clamp    = (bus.shamt > SW'(WIDTH)) ? SW'(WIDTH)
                                               : bus.shamt;

  always_comb begin
    w_nstate  = r_state;
    w_nq      = r_q;
    w_nsticky = r_sticky;
    w_ncnt    = r_cnt;
    w_nmode   = r_mode;
    w_nser    = r_ser;
    unique case (r_state)
      IDLE: begin
        if (bus.en) begin
          if (bus.start && w_is_shift) begin
            w_nmode   = bus.mode;
            w_nser    = bus.ser_in;
            w_nsticky = 1'b0;
            w_ncnt    = w_clamp;
            w_nstate  = (w_clamp == '0) ? DONE : RUN;
          end else if (bus.mode == M_LOAD) begin
            w_nq      = bus.load_data;
            w_nsticky = 1'b0;
          end else begin
            w_nq      = f_step(r_q, bus.mode, bus.ser_in);
            w_nsticky = f_sticky(r_sticky, bus.mode, r_q[0]);
          end
        end
      end
      RUN: begin
        if (bus.en) begin
          w_nq      = f_step(r_q, r_mode, r_ser);
          w_nsticky = f_sticky(r_sticky, r_mode, r_q[0]);
          w_ncnt    = r_cnt - SW'(1);
          if (r_cnt == SW'(1)) w_nstate = DONE;
        end
      end
      DONE: w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_mode   <= M_HOLD;
      r_ser    <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_q      <= w_nq;
      r_sticky <= w_nsticky;
      r_cnt    <= w_ncnt;
      r_mode   <= w_nmode;
      r_ser    <= w_nser;
    end
  end

  assign bus.Q         = r_q;
  assign bus.ser_out_l = r_q[WIDTH-1];
  assign bus.ser_out_r = r_q[0];
  assign bus.sticky    = r_sticky;
  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == DONE);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register.
// Hand-computed vectors checked with immediate assertions.
module tb_universal_shift_register;

  logic clk;
  logic rst_n;
  int   n_tot;
  int   n_pass;
  int   n_done;

  universal_shift_register_if #(.WIDTH(32), .SW(6)) bus ();

  universal_shift_register #(.WIDTH(32), .SW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set(input logic [2:0] m, input logic [31:0] d,
                     input logic s, input logic st,
                     input logic [5:0] sh);
    bus.mode      = m;
    bus.load_data = d;
    bus.ser_in    = s;
    bus.start     = st;
    bus.shamt     = sh;
  endtask

  initial begin
    n_tot  = 0;
    n_pass = 0;
    n_done = 0;
    rst_n  = 1'b0;
    bus.en = 1'b1;
    set(3'b000, '0, 1'b0, 1'b0, '0);
    #12;
    chk("rst_q", bus.Q, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    chk("rst_sticky", {31'b0, bus.sticky}, 32'h0);
    rst_n = 1'b1;
    tick();

    // load, single-cycle SLL then SRL
    set(3'b001, 32'hA5A5_0F0F, 1'b0, 1'b0, '0);
    tick();
    chk("load_q", bus.Q, 32'hA5A5_0F0F);
    chk("load_sol", {31'b0, bus.ser_out_l}, 32'h1);
    chk("load_sor", {31'b0, bus.ser_out_r}, 32'h1);
    set(3'b010, '0, 1'b1, 1'b0, '0);
    tick();
    chk("sll_q", bus.Q, 32'h4B4A_1E1F);
    chk("sll_sol", {31'b0, bus.ser_out_l}, 32'h0);
    chk("sll_sticky", {31'b0, bus.sticky}, 32'h0);
    set(3'b011, '0, 1'b0, 1'b0, '0);
    tick();
    chk("srl_q", bus.Q, 32'h25A5_0F0F);
    chk("srl_sticky", {31'b0, bus.sticky}, 32'h1);

    // en low and reserved mode both hold
    bus.en = 1'b0;
    set(3'b001, 32'h1111_1111, 1'b0, 1'b0, '0);
    tick();
    chk("en0_q", bus.Q, 32'h25A5_0F0F);
    bus.en = 1'b1;
    set(3'b111, 32'h1111_1111, 1'b1, 1'b0, '0);
    tick();
    chk("rsv_q", bus.Q, 32'h25A5_0F0F);

    // sequenced SRA by 5
    set(3'b001, 32'h8000_0013, 1'b0, 1'b0, '0);
    tick();
    set(3'b100, '0, 1'b0, 1'b1, 6'd5);
    tick();
    set(3'b000, '0, 1'b0, 1'b0, '0);
    chk("sra_stky_clr", {31'b0, bus.sticky}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("sra_busy", {31'b0, bus.busy}, 32'h1);
      chk("sra_nodone", {31'b0, bus.done}, 32'h0);
      tick();
    end
    chk("sra_done", {31'b0, bus.done}, 32'h1);
    chk("sra_busy0", {31'b0, bus.busy}, 32'h0);
    chk("sra_q", bus.Q, 32'hFC00_0000);
    chk("sra_sticky", {31'b0, bus.sticky}, 32'h1);
    tick();
    chk("sra_done0", {31'b0, bus.done}, 32'h0);

    // ROL by 40 clamps to 32 and restores
    set(3'b001, 32'h1234_5678, 1'b0, 1'b0, '0);
    tick();
    set(3'b101, '0, 1'b0, 1'b1, 6'd40);
    tick();
    set(3'b000, '0, 1'b0, 1'b0, '0);
    repeat (31) tick();
    chk("rol_busy31", {31'b0, bus.busy}, 32'h1);
    tick();
    chk("rol_done", {31'b0, bus.done}, 32'h1);
    chk("rol_q", bus.Q, 32'h1234_5678);
    chk("rol_sticky", {31'b0, bus.sticky}, 32'h0);
    tick();

    // SRL by 8 with a 3-cycle enable gap
    set(3'b001, 32'h0000_00F0, 1'b0, 1'b0, '0);
    tick();
    set(3'b011, '0, 1'b0, 1'b1, 6'd8);
    tick();
    set(3'b001, 32'hFFFF_FFFF, 1'b1, 1'b0, '0);
    repeat (4) begin
      if (bus.done) n_done++;
      tick();
    end
    chk("gap_q4", bus.Q, 32'h0000_000F);
    bus.en = 1'b0;
    repeat (3) begin
      if (bus.done) n_done++;
      tick();
      chk("gap_busy", {31'b0, bus.busy}, 32'h1);
    end
    chk("gap_qfrz", bus.Q, 32'h0000_000F);
    bus.en = 1'b1;
    repeat (4) begin
      if (bus.done) n_done++;
      tick();
    end
    chk("gap_q", bus.Q, 32'h0);
    chk("gap_sticky", {31'b0, bus.sticky}, 32'h1);
    if (bus.done) n_done++;
    bus.mode = 3'b000;
    tick();
    if (bus.done) n_done++;
    chk("gap_ndone", n_done, 32'd1);

    // zero-count start, then start with LOAD
    set(3'b001, 32'h0000_ABCD, 1'b0, 1'b0, '0);
    tick();
    set(3'b010, '0, 1'b1, 1'b1, 6'd0);
    tick();
    set(3'b000, '0, 1'b0, 1'b0, '0);
    chk("z_done", {31'b0, bus.done}, 32'h1);
    chk("z_busy", {31'b0, bus.busy}, 32'h0);
    chk("z_q", bus.Q, 32'h0000_ABCD);
    tick();
    chk("z_done0", {31'b0, bus.done}, 32'h0);
    set(3'b001, 32'h5555_AAAA, 1'b0, 1'b1, 6'd3);
    tick();
    set(3'b000, '0, 1'b0, 1'b0, '0);
    chk("ldst_q", bus.Q, 32'h5555_AAAA);
    chk("ldst_done", {31'b0, bus.done}, 32'h0);
    chk("ldst_busy", {31'b0, bus.busy}, 32'h0);
    tick();
    chk("ldst_done1", {31'b0, bus.done}, 32'h0);

    // start re-asserted during RUN is ignored
    set(3'b001, 32'h0000_000F, 1'b0, 1'b0, '0);
    tick();
    set(3'b110, '0, 1'b0, 1'b1, 6'd3);
    tick();
    set(3'b011, 32'h0, 1'b1, 1'b1, 6'd10);
    repeat (3) tick();
    chk("rr_done", {31'b0, bus.done}, 32'h1);
    chk("rr_q", bus.Q, 32'hE000_0001);
    chk("rr_sticky", {31'b0, bus.sticky}, 32'h0);
    set(3'b000, '0, 1'b0, 1'b0, '0);
    tick();
    chk("rr_idle", {31'b0, bus.busy}, 32'h0);

    // async reset mid-run
    set(3'b001, 32'hFFFF_0000, 1'b0, 1'b0, '0);
    tick();
    set(3'b011, '0, 1'b0, 1'b1, 6'd10);
    tick();
    set(3'b000, '0, 1'b0, 1'b0, '0);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_q", bus.Q, 32'h0);
    chk("ar_busy", {31'b0, bus.busy}, 32'h0);
    #1 rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      tick();
      if (bus.done) n_done++;
    end
    chk("ar_nodone", n_done, 32'd0);
    chk("ar_q2", bus.Q, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the fixed 32-bit serial-in shift chain in the datapath register library. It supports a configurable width and a synchronous parallel load. It performs single-cycle shift and rotate operations in both directions, plus a sequenced multi-bit shift with a start/busy/done handshake. It sits in the FP32 datapath for mantissa alignment and normalisation; the sticky output feeds rounding.

Parameters:
WIDTH, 32, register width in bits (≥2)
SW, $clog2(WIDTH)+1, width of shift-amount port; must be able to encode WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  clock enable; when low nothing changes except reset
mode  input  3  operation select (encoding below)
load_data  input  WIDTH  parallel load value
ser_in  input  1  serial fill bit for logical shifts
start  input  1  request a sequenced shift of shamt positions using mode
shamt  input  SW  sequenced shift amount
Q  output  WIDTH  register contents
ser_out_l  output  1  Q[WIDTH-1] (combinational)
ser_out_r  output  1  Q[0] (combinational)
sticky  output  1  OR of all bits shifted out by right shifts since last load/start
busy  output  1  sequenced shift in progress
done  output  1  one-cycle pulse at end of a sequenced shift

Behaviour:
- Reset (rst_n=0, async): Q=0, sticky=0, busy=0, done=0, FSM=IDLE, counter=0, latched mode/ser_in=0. Reset mid-run aborts the run; no done pulse.
- Left = toward MSB.
- Mode encoding:
  - 000 HOLD.
  - 001 LOAD: Q<=load_data.
  - 010 SLL: Q<={Q[W-2:0],ser_in}.
  - 011 SRL: Q<={ser_in,Q[W-1:1]}.
  - 100 SRA: Q<={Q[W-1],Q[W-1:1]}.
  - 101 ROL: Q<={Q[W-2:0],Q[W-1]}.
  - 110 ROR: Q<={Q[0],Q[W-1:1]}.
  - 111 reserved, acts as HOLD.
- FSM states: IDLE, RUN, DONE.
- IDLE, en=1, start=0: apply mode once, single-cycle; result visible the cycle after the edge.
- IDLE, en=1, start=1, mode is a shift/rotate (010–110):
  - latch mode and ser_in; clear sticky; load counter with min(shamt, WIDTH).
  - If the clamped count is 0: go to DONE, Q unchanged.
  - Otherwise go to RUN; no shift occurs on the start edge.
- IDLE, en=1, start=1, mode HOLD/LOAD/111: start is ignored and the mode executes as a single-cycle op.
- RUN:
  - busy=1.
  - Each en=1 edge: one step of the latched op with the latched ser_in; counter-1.
  - When the counter reaches 0 after the step, go to DONE.
  - en=0 freezes Q, counter and state.
  - mode, start, ser_in and load_data are ignored; LOAD is not possible while busy.
- DONE: done=1 for one cycle, busy=0, then IDLE regardless of en. Latency from the start edge = shamt+1 enabled edges to DONE.
- sticky:
  - Cleared on LOAD and on an accepted start.
  - Set (OR) with the outgoing Q[0] on every SRL or SRA step, single-cycle or sequenced.
  - Unaffected by left shifts, rotates and HOLD. Reset value 0.
- Output timing: busy and done are registered/state-decoded and glitch-free; ser_out_l and ser_out_r are combinational from Q.
- Sequenced SRL/SLL by WIDTH with ser_in=0 yields Q=0. A sequenced rotate by WIDTH restores the original Q.

Test Plan:
- Reset then LOAD 0xA5A5_0F0F, SLL ser_in=1 ×1 -> Q=0x4B4A_1E1F; then SRL ser_in=0 ×1 -> Q=0x25A5_0F0F, sticky=1.
- LOAD 0x8000_0013, start SRA shamt=5 -> busy high 5 cycles; done pulses at edge 6; Q=0xFC00_0000; sticky=1.
- LOAD 0x1234_5678, start ROL shamt=40 (clamped to 32) -> 32 steps, Q=0x1234_5678, sticky=0.
- LOAD 0x0000_00F0, start SRL shamt=8 with en low for 3 cycles mid-run -> busy stays high; Q=0x0000_0000 after 8 enabled steps; sticky=1; done once.
- start SLL shamt=0 -> no busy; done pulses the next cycle; Q unchanged. start with mode=LOAD -> acts as a plain load; no done.
- Mid-run async reset (rst_n low between edges) -> Q=0, busy=0, no done. start asserted during RUN is ignored; the run completes with its original count.
